pixel_writer: RTL and testbench
===============================

Name: pixel_writer

Overview:
- Downstream stage of the line drawer: consumes its (draw_x, draw_y, color) pixel stream over the rts/rtr handshake and writes each pixel into the framebuffer memory.
- Buffers pixels in a small FIFO and clips off-screen coordinates.
- Converts each surviving pixel to a linear framebuffer address (y*H_RES + x) and runs a req/ack write transaction per pixel.
- Keeps written and clipped pixel counters for debug.

Parameters:
- H_RES, 640, visible width in pixels; also the row stride of the address.
- V_RES, 480, visible height in pixels.
- ADDR_W, 19, framebuffer address width; must hold H_RES*V_RES-1.
- FIFO_DEPTH, 4, pixel FIFO entries; power of 2, minimum 2.

Ports:
- clk  input  1  system clock
- rst_  input  1  asynchronous active-low reset
- in_rts  input  1  upstream has a pixel
- in_rtr  output  1  block can accept a pixel
- in_x  input  10  pixel x
- in_y  input  10  pixel y
- in_color  input  12  pixel colour, RGB 4:4:4
- mem_req  output  1  write request to the framebuffer
- mem_ack  input  1  framebuffer accepted the write
- mem_addr  output  ADDR_W  write address
- mem_data  output  12  write data
- clear_counts  input  1  synchronous clear of both counters
- write_count  output  16  pixels written, saturating
- clip_count  output  16  pixels dropped by clipping, saturating
- busy  output  1  FIFO not empty or write FSM not idle

Behaviour:
- Reset (async, rst_ low) forces, immediately:
  - FIFO empty, FSM in M_IDLE.
  - mem_req=0, mem_addr=0, mem_data=0.
  - write_count=0, clip_count=0, busy=0.
  - in_rtr follows from the empty FIFO and becomes 1.
  - Reset mid-transaction drops mem_req at once; the pixel in flight is lost and is not counted.
- Input handshake:
  - in_xfc = in_rts & in_rtr.
  - in_rtr = (FIFO count < FIFO_DEPTH), decoded from registered count only. No full-FIFO bypass: when full, in_rtr=0 even if a pop happens in the same cycle.
- Clipping at input:
  - On in_xfc, a pixel with in_x >= H_RES or in_y >= V_RES is accepted but not pushed; clip_count increments.
  - Any other accepted pixel is pushed (x, y, color).
  - Comparisons are unsigned.
- FIFO:
  - Circular buffer with read/write pointers and a count.
  - Push and pop in the same cycle leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Write FSM:
  - M_IDLE: if FIFO not empty, latch the head entry into internal x/y/color registers, pop, and go to M_ADDR. Otherwise stay.
  - M_ADDR: mem_addr <= y*H_RES + x, computed at ADDR_W bits with no overflow for in-range pixels (default stride may use (y<<9)+(y<<7)). mem_data <= color. Go to M_WRITE.
  - M_WRITE: mem_req=1 with mem_addr/mem_data held stable. On mem_ack: increment write_count, go to M_IDLE. Otherwise stay, with no timeout.
  - mem_req is decoded combinationally from state == M_WRITE.
- Latency and throughput:
  - A pixel accepted at edge N into an empty, idle block is popped at edge N+1.
  - mem_req is high during the cycle after edge N+2.
  - Minimum 3 cycles per pixel when mem_ack returns in the first request cycle.
- Counters:
  - 16-bit, saturate at 0xFFFF.
  - clear_counts sets both to 0 at the next edge and wins over a same-cycle increment.
  - A clip and a write in the same cycle each update their own counter.
- busy = (count != 0) | (state != M_IDLE); it is registered-derived and combinational.
- mem_ack outside M_WRITE is ignored.
- Illegal state encoding returns to M_IDLE.

Test Plan:
- Single pixel (5,2,0xF00), mem_ack tied 1:
  - mem_req is high exactly 1 cycle, 3 cycles after acceptance.
  - mem_addr=1285, mem_data=0xF00, write_count=1, then busy=0.
- Clipping: send (640,0), (0,480), (639,479):
  - clip_count=2, write_count=1.
  - Single write at addr 307199.
- Backpressure: mem_ack held 0, send 6 pixels back to back:
  - in_rtr drops after FIFO_DEPTH+1 accepted (4 queued plus 1 latched in the FSM).
  - Releasing mem_ack drains them in input order with correct addresses.
- Slow memory: mem_ack asserted 4 cycles after mem_req:
  - mem_addr/mem_data stay stable throughout.
  - Exactly one count per ack.
- Reset mid-write: assert rst_=0 while mem_req=1 with 2 pixels queued:
  - mem_req=0 immediately, FIFO empty, counters 0.
  - After release in_rtr=1 and no further writes occur.
- Counters: preload near saturation by streaming 65537 clipped pixels:
  - clip_count=0xFFFF.
  - clear_counts pulsed with a simultaneous clip leaves clip_count=0.

Source files
------------

// File: rtl/pixel_writer.sv
// Buffers the line drawer's pixel stream, clips off-screen pixels, and writes each survivor to the framebuffer.
// Latency: a pixel accepted into an empty, idle block has mem_req high 3 cycles later; minimum 3 cycles per pixel.
// Backpressure: in_rtr is low while the FIFO is full; mem_req is held with a stable address/data until mem_ack, with no timeout.
module pixel_writer #(
    parameter int unsigned H_RES      = 640,
    parameter int unsigned V_RES      = 480,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              in_rts,
    output logic              in_rtr,
    input  logic [9:0]        in_x,
    input  logic [9:0]        in_y,
    input  logic [11:0]       in_color,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [11:0]       mem_data,
    input  logic              clear_counts,
    output logic [15:0]       write_count,
    output logic [15:0]       clip_count,
    output logic              busy
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] color;
    } pix_t;

    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_ADDR  = 2'd1,
        M_WRITE = 2'd2
    } state_t;

    pix_t          fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    state_t        state;
    logic [9:0]    x_q;
    logic [9:0]    y_q;
    logic [11:0]   color_q;

    logic          in_xfc;
    logic          clip;
    logic          push;
    logic          pop;

    // in_rtr comes from the registered count only, so a full FIFO stalls even if a pop is under way
    assign in_rtr  = (count < CW'(FIFO_DEPTH));
    assign in_xfc  = in_rts & in_rtr;
    assign clip    = in_xfc & ((32'(in_x) >= H_RES) | (32'(in_y) >= V_RES));
    assign push    = in_xfc & ~clip;
    assign pop     = (state == M_IDLE) & (count != '0);
    assign mem_req = (state == M_WRITE);
    assign busy    = (count != '0) | (state != M_IDLE);

    // FIFO storage; contents are don't-care while empty, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{x: in_x, y: in_y, color: in_color};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Write FSM: latch head, form the linear address, then hold the request until acknowledged
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state       <= M_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            color_q     <= '0;
            mem_addr    <= '0;
            mem_data    <= '0;
            write_count <= '0;
        end else begin
            case (state)
                M_IDLE: begin
                    if (pop) begin
                        x_q     <= fifo_mem[rd_ptr].x;
                        y_q     <= fifo_mem[rd_ptr].y;
                        color_q <= fifo_mem[rd_ptr].color;
                        state   <= M_ADDR;
                    end
                end
                M_ADDR: begin
                    mem_addr <= ADDR_W'(y_q) * ADDR_W'(H_RES) + ADDR_W'(x_q);
                    mem_data <= color_q;
                    state    <= M_WRITE;
                end
                M_WRITE: begin
                    if (mem_ack) begin
                        state <= M_IDLE;
                    end
                end
                default: state <= M_IDLE;
            endcase

            // clear wins over a same-cycle completed write
            if (clear_counts) begin
                write_count <= '0;
            end else if ((state == M_WRITE) && mem_ack && (write_count != 16'hFFFF)) begin
                write_count <= write_count + 16'd1;
            end
        end
    end

    // Saturating count of pixels dropped at the input for being off-screen
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            clip_count <= '0;
        end else if (clear_counts) begin
            clip_count <= '0;
        end else if (clip && (clip_count != 16'hFFFF)) begin
            clip_count <= clip_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pixel_writer.sv
// Directed testbench for pixel_writer: single pixel, clipping, backpressure,
// slow memory, reset mid-write and counter saturation/clear.
module tb_pixel_writer;

    logic        clk;
    logic        rst_;
    logic        in_rts;
    logic        in_rtr;
    logic [9:0]  in_x;
    logic [9:0]  in_y;
    logic [11:0] in_color;
    logic        mem_req;
    logic        mem_ack;
    logic [18:0] mem_addr;
    logic [11:0] mem_data;
    logic        clear_counts;
    logic [15:0] write_count;
    logic [15:0] clip_count;
    logic        busy;

    int total = 0;
    int bad   = 0;

    pixel_writer #(
        .H_RES(640), .V_RES(480), .ADDR_W(19), .FIFO_DEPTH(4)
    ) dut (
        .clk          (clk),
        .rst_         (rst_),
        .in_rts       (in_rts),
        .in_rtr       (in_rtr),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_color     (in_color),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .clear_counts (clear_counts),
        .write_count  (write_count),
        .clip_count   (clip_count),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rts, input int x, input int y, input int c);
        in_rts   = rts;
        in_x     = 10'(x);
        in_y     = 10'(y);
        in_color = 12'(c);
    endtask

    logic [18:0] wr_addr [8];
    logic [11:0] wr_data [8];
    int          n_wr;
    int          req_cycles;
    logic        stable;
    logic        acc;

    initial begin
        rst_ = 1'b0;
        mem_ack = 1'b0;
        clear_counts = 1'b0;
        drive(1'b0, 0, 0, 0);
        #1;
        check("rst_req",   32'(mem_req), 0);
        check("rst_addr",  32'(mem_addr), 0);
        check("rst_data",  32'(mem_data), 0);
        check("rst_wcnt",  32'(write_count), 0);
        check("rst_ccnt",  32'(clip_count), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_rtr",   32'(in_rtr), 1);
        tick(); tick();
        rst_ = 1'b1;
        tick();

        // single pixel (5,2,F00), mem_ack tied high
        mem_ack = 1'b1;
        drive(1'b1, 5, 2, 'hF00);
        tick();
        drive(1'b0, 0, 0, 0);
        check("t1_req_n1", 32'(mem_req), 0);
        check("t1_busy",   32'(busy), 1);
        tick();
        check("t1_req_n2", 32'(mem_req), 0);
        tick();
        check("t1_req_n3", 32'(mem_req), 1);
        check("t1_addr",   32'(mem_addr), 1285);
        check("t1_data",   32'(mem_data), 'hF00);
        tick();
        check("t1_req_off", 32'(mem_req), 0);
        check("t1_wcnt",    32'(write_count), 1);
        check("t1_idle",    32'(busy), 0);

        // clipping: clear counters, then two off-screen and one corner pixel
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        drive(1'b1, 640, 0, 'h111);
        tick();
        drive(1'b1, 0, 480, 'h222);
        tick();
        drive(1'b1, 639, 479, 'h0AB);
        tick();
        drive(1'b0, 0, 0, 0);
        req_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem_req) begin
                req_cycles++;
                wr_addr[0] = mem_addr;
                wr_data[0] = mem_data;
            end
            tick();
        end
        check("t2_ccnt",  32'(clip_count), 2);
        check("t2_wcnt",  32'(write_count), 1);
        check("t2_nreq",  32'(req_cycles), 1);
        check("t2_addr",  32'(wr_addr[0]), 307199);
        check("t2_data",  32'(wr_data[0]), 'h0AB);

        // backpressure: memory stalled, six pixels offered back to back
        mem_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 10 + k, 20 + k, 'h100 + k);
            tick();
        end
        drive(1'b1, 15, 25, 'h105);
        check("t3_rtr_low", 32'(in_rtr), 0);
        tick(); tick();
        check("t3_rtr_hold", 32'(in_rtr), 0);
        check("t3_req",      32'(mem_req), 1);
        check("t3_head",     32'(mem_addr), 12810);
        mem_ack = 1'b1;
        n_wr = 0;
        for (int i = 0; i < 40; i++) begin
            if (mem_req && mem_ack && n_wr < 8) begin
                wr_addr[n_wr] = mem_addr;
                wr_data[n_wr] = mem_data;
                n_wr++;
            end
            acc = in_rts & in_rtr;
            tick();
            if (acc) in_rts = 1'b0;
        end
        check("t3_nwr", 32'(n_wr), 6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t3_addr%0d", k), 32'(wr_addr[k]), (20 + k) * 640 + 10 + k);
            check($sformatf("t3_data%0d", k), 32'(wr_data[k]), 'h100 + k);
        end
        check("t3_wcnt", 32'(write_count), 7);
        check("t3_idle", 32'(busy), 0);

        // slow memory: ack arrives 4 cycles after the request rises
        mem_ack = 1'b0;
        drive(1'b1, 3, 4, 'h0CC);
        tick();
        drive(1'b0, 0, 0, 0);
        tick(); tick();
        stable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (!(mem_req && mem_addr == 19'd2563 && mem_data == 12'h0CC)) stable = 1'b0;
            tick();
        end
        check("t4_stable", 32'(stable), 1);
        check("t4_req_wait", 32'(mem_req), 1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("t4_req_off", 32'(mem_req), 0);
        check("t4_wcnt",    32'(write_count), 8);
        mem_ack = 1'b1;
        tick(); tick(); tick();
        mem_ack = 1'b0;
        check("t4_ack_idle", 32'(write_count), 8);

        // reset while a write is pending and two pixels are queued
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 30 + k, 40 + k, 'h300 + k);
            tick();
        end
        drive(1'b0, 0, 0, 0);
        check("t5_req_pre", 32'(mem_req), 1);
        rst_ = 1'b0;
        #1;
        check("t5_req_rst",  32'(mem_req), 0);
        check("t5_busy_rst", 32'(busy), 0);
        check("t5_wcnt_rst", 32'(write_count), 0);
        check("t5_ccnt_rst", 32'(clip_count), 0);
        check("t5_rtr_rst",  32'(in_rtr), 1);
        tick();
        rst_ = 1'b1;
        mem_ack = 1'b1;
        req_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req) req_cycles++;
            tick();
        end
        check("t5_nreq", 32'(req_cycles), 0);
        check("t5_rtr",  32'(in_rtr), 1);
        check("t5_wcnt", 32'(write_count), 0);
        mem_ack = 1'b0;

        // counter saturation, then clear against a simultaneous clip
        drive(1'b1, 700, 0, 0);
        repeat (65537) tick();
        check("t6_sat", 32'(clip_count), 'hFFFF);
        check("t6_busy", 32'(busy), 0);
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        drive(1'b0, 0, 0, 0);
        check("t6_clear", 32'(clip_count), 0);
        tick();
        check("t6_after", 32'(clip_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
